// File: rtl/pad_bus_pkg.sv
// Shared types and helpers for the pad-to-memory-bus bridge.
package pad_bus_pkg;

    // Access size encoding as driven by the operation controller.
    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_ILLEGAL = 2'b10,
        SIZE_WORD    = 2'b11
    } size_e;

    // Bridge FSM states.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // Width of the ACCESS-state wait counter.
    localparam int TIMEOUT_W = 8;

    // Active byte lanes for an access of the given size at the given low address bits.
    function automatic logic [3:0] byte_enable(size_e size, logic [1:0] addr);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addr;
            SIZE_HALF: be = 4'b0011 << {addr[1], 1'b0};
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // True when the access cannot be issued: wrong alignment or illegal size code.
    function automatic logic misaligned(size_e size, logic [1:0] addr);
        logic bad;
        case (size)
            SIZE_HALF:    bad = addr[0];
            SIZE_WORD:    bad = (addr != 2'b00);
            SIZE_ILLEGAL: bad = 1'b1;
            default:      bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/pad_bus_interface_aligner.sv
// Combinational lane logic: byte enables and store replication for the request side,
// lane extraction and zero fill for the response side.
module pad_lane_aligner
    import pad_bus_pkg::*;
(
    input  size_e       req_size_i,
    input  logic [1:0]  req_addr_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  byte_enable_o,
    output logic [31:0] wdata_o,
    input  size_e       rsp_size_i,
    input  logic [1:0]  rsp_addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] rdata_o
);

    assign byte_enable_o = byte_enable(req_size_i, req_addr_i);

    // Replicate store data so every lane the byte enables select carries it.
    always_comb begin
        wdata_o = wdata_i;
        case (req_size_i)
            SIZE_BYTE: wdata_o = {4{wdata_i[7:0]}};
            SIZE_HALF: wdata_o = {2{wdata_i[15:0]}};
            default:   wdata_o = wdata_i;
        endcase
    end

    // Pull the addressed lane(s) down to bit 0 and zero-fill the rest.
    always_comb begin
        rdata_o = rdata_i;
        case (rsp_size_i)
            SIZE_BYTE: begin
                case (rsp_addr_i)
                    2'd0:    rdata_o = {24'b0, rdata_i[7:0]};
                    2'd1:    rdata_o = {24'b0, rdata_i[15:8]};
                    2'd2:    rdata_o = {24'b0, rdata_i[23:16]};
                    default: rdata_o = {24'b0, rdata_i[31:24]};
                endcase
            end
            SIZE_HALF: rdata_o = rsp_addr_i[1] ? {16'b0, rdata_i[31:16]} : {16'b0, rdata_i[15:0]};
            default:   rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/pad_bus_interface.sv
// Bridge from core pad requests to a valid/ready memory bus.
// Handshake: a transfer completes in any cycle where mem_valid and mem_ready are both high;
// mem_write/mem_address/mem_byte_enable/mem_wdata are held stable while mem_valid is high,
// and mem_valid only drops on completion, timeout abort or reset.
module pad_bus_interface
    import pad_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pad_read,
    input  logic        pad_write,
    input  logic [1:0]  pad_data_size,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        bus_error,
    output logic        mem_valid,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output state_e      debug_state
);

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [TIMEOUT_W-1:0]   counter_q, counter_d;
    logic                   mem_valid_q, mem_valid_d;
    logic                   mem_write_q, mem_write_d;
    logic [31:0]            mem_address_q, mem_address_d;
    logic [3:0]             mem_byte_enable_q, mem_byte_enable_d;
    logic [31:0]            mem_wdata_q, mem_wdata_d;
    logic [31:0]            read_data_q, read_data_d;
    logic                   bus_error_q, bus_error_d;
    size_e                  size_q, size_d;
    logic [1:0]             addr_lo_q, addr_lo_d;

    size_e                  req_size;
    logic                   request;
    logic                   req_error;
    logic [3:0]             req_be;
    logic [31:0]            req_wdata;
    logic [31:0]            rsp_rdata;

    assign req_size  = size_e'(pad_data_size);
    assign request   = pad_read | pad_write;
    assign req_error = (pad_read & pad_write) | misaligned(req_size, address[1:0]);

    pad_lane_aligner u_aligner (
        .req_size_i    (req_size),
        .req_addr_i    (address[1:0]),
        .wdata_i       (write_data),
        .byte_enable_o (req_be),
        .wdata_o       (req_wdata),
        .rsp_size_i    (size_q),
        .rsp_addr_i    (addr_lo_q),
        .rdata_i       (mem_rdata),
        .rdata_o       (rsp_rdata)
    );

    // Next-state, stall and read_data bypass; registered bus fields hold by default.
    always_comb begin
        state_d           = state_q;
        counter_d         = counter_q;
        mem_valid_d       = mem_valid_q;
        mem_write_d       = mem_write_q;
        mem_address_d     = mem_address_q;
        mem_byte_enable_d = mem_byte_enable_q;
        mem_wdata_d       = mem_wdata_q;
        read_data_d       = read_data_q;
        bus_error_d       = 1'b0;
        size_d            = size_q;
        addr_lo_d         = addr_lo_q;
        stall             = 1'b0;
        read_data         = read_data_q;
        case (state_q)
            IDLE: begin
                if (request) begin
                    if (req_error) begin
                        bus_error_d = 1'b1;
                        read_data_d = 32'b0;
                    end else begin
                        stall             = 1'b1;
                        state_d           = ACCESS;
                        counter_d         = '0;
                        mem_valid_d       = 1'b1;
                        mem_write_d       = pad_write;
                        mem_address_d     = {address[31:2], 2'b00};
                        mem_byte_enable_d = req_be;
                        mem_wdata_d       = req_wdata;
                        size_d            = req_size;
                        addr_lo_d         = address[1:0];
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    // Completion: the consumer samples read data at this same edge.
                    mem_valid_d = 1'b0;
                    state_d     = IDLE;
                    if (!mem_write_q) begin
                        read_data   = rsp_rdata;
                        read_data_d = rsp_rdata;
                    end
                end else if (counter_q == TIMEOUT_LAST) begin
                    // Abort: release the pipeline now, flag the error next cycle.
                    mem_valid_d = 1'b0;
                    bus_error_d = 1'b1;
                    read_data_d = 32'b0;
                    state_d     = IDLE;
                end else begin
                    stall     = 1'b1;
                    counter_d = counter_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and bus output registers; reset abandons any transfer in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            counter_q         <= '0;
            mem_valid_q       <= 1'b0;
            mem_write_q       <= 1'b0;
            mem_address_q     <= 32'b0;
            mem_byte_enable_q <= 4'b0;
            mem_wdata_q       <= 32'b0;
            read_data_q       <= 32'b0;
            bus_error_q       <= 1'b0;
            size_q            <= SIZE_BYTE;
            addr_lo_q         <= 2'b00;
        end else begin
            state_q           <= state_d;
            counter_q         <= counter_d;
            mem_valid_q       <= mem_valid_d;
            mem_write_q       <= mem_write_d;
            mem_address_q     <= mem_address_d;
            mem_byte_enable_q <= mem_byte_enable_d;
            mem_wdata_q       <= mem_wdata_d;
            read_data_q       <= read_data_d;
            bus_error_q       <= bus_error_d;
            size_q            <= size_d;
            addr_lo_q         <= addr_lo_d;
        end
    end

    assign mem_valid       = mem_valid_q;
    assign mem_write       = mem_write_q;
    assign mem_address     = mem_address_q;
    assign mem_byte_enable = mem_byte_enable_q;
    assign mem_wdata       = mem_wdata_q;
    assign bus_error       = bus_error_q;
    assign debug_state     = state_q;

endmodule

// File: tb/tb_pad_bus_interface.sv
// Directed bench for pad_bus_interface: reads/writes of each size, wait states,
// error rejection, timeout abort and asynchronous reset mid-access.
module tb_pad_bus_interface;
    import pad_bus_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pad_read = 1'b0;
    logic        pad_write = 1'b0;
    logic [1:0]  pad_data_size = 2'b00;
    logic [31:0] address = 32'b0;
    logic [31:0] write_data = 32'b0;
    logic [31:0] read_data;
    logic        stall;
    logic        bus_error;
    logic        mem_valid;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'b0;
    state_e      debug_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = 32'b0;

    pad_bus_interface #(.TIMEOUT_CYCLES(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .pad_read        (pad_read),
        .pad_write       (pad_write),
        .pad_data_size   (pad_data_size),
        .address         (address),
        .write_data      (write_data),
        .read_data       (read_data),
        .stall           (stall),
        .bus_error       (bus_error),
        .mem_valid       (mem_valid),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata),
        .debug_state     (debug_state)
    );

    // Clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Full legal access; entered and left just after a falling edge.
    task automatic run_access(input logic is_write, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rdata, input int waits,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_rdata);
        int stall_cnt;
        logic [31:0] exp_rd;
        stall_cnt = 0;
        if (!is_write) exp_q.push_back(exp_rdata);
        pad_read = ~is_write; pad_write = is_write; pad_data_size = size;
        address = addr; write_data = wd; mem_ready = 1'b0;
        #1 check("req_stall", {31'b0, stall}, 32'd1);
        check("req_no_valid", {31'b0, mem_valid}, 32'd0);
        if (stall) stall_cnt++;
        @(posedge clock); #1;
        check("valid_set", {31'b0, mem_valid}, 32'd1);
        check("mem_write", {31'b0, mem_write}, {31'b0, is_write});
        check("mem_address", mem_address, {addr[31:2], 2'b00});
        check("byte_enable", {28'b0, mem_byte_enable}, {28'b0, exp_be});
        if (is_write) check("mem_wdata", mem_wdata, exp_wdata);
        @(negedge clock);
        pad_read = 1'b0; pad_write = 1'b0;
        for (int i = 0; i < waits; i++) begin
            #1 if (stall) stall_cnt++;
            @(posedge clock); #1;
            check("valid_hold", {31'b0, mem_valid}, 32'd1);
            check("addr_hold", mem_address, {addr[31:2], 2'b00});
            @(negedge clock);
        end
        mem_ready = 1'b1; mem_rdata = rdata;
        #1 check("done_stall", {31'b0, stall}, 32'd0);
        if (!is_write) begin
            exp_rd = exp_q.pop_front();
            check("rd_bypass", read_data, exp_rd);
            last_rd = exp_rd;
        end
        @(posedge clock); #1;
        check("valid_clr", {31'b0, mem_valid}, 32'd0);
        check("rd_held", read_data, last_rd);
        check("stall_cycles", stall_cnt, waits + 1);
        @(negedge clock);
        mem_ready = 1'b0;
    endtask

    // Rejected request: no bus cycle, one-cycle error pulse, read_data cleared.
    task automatic run_error(input logic rd, input logic wr, input logic [1:0] size, input logic [31:0] addr);
        pad_read = rd; pad_write = wr; pad_data_size = size; address = addr;
        #1 check("err_stall", {31'b0, stall}, 32'd0);
        @(posedge clock); #1;
        check("err_no_valid", {31'b0, mem_valid}, 32'd0);
        check("err_pulse", {31'b0, bus_error}, 32'd1);
        check("err_rd_clr", read_data, 32'd0);
        check("err_state", 32'(debug_state), 32'(IDLE));
        last_rd = 32'b0;
        @(negedge clock);
        pad_read = 1'b0; pad_write = 1'b0;
        @(posedge clock); #1;
        check("err_pulse_end", {31'b0, bus_error}, 32'd0);
        @(negedge clock);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_error", {31'b0, bus_error}, 32'd0);
        check("rst_rdata", read_data, 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_be", {28'b0, mem_byte_enable}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_state", 32'(debug_state), 32'(IDLE));
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Word read, zero wait
        run_access(1'b0, 2'b11, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        // Byte store at lane 3, three wait states; read_data keeps the previous load
        run_access(1'b1, 2'b00, 32'h0000_0203, 32'h0000_00A5, 32'h0, 3, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        // Upper half read
        run_access(1'b0, 2'b01, 32'h0000_0012, 32'h0, 32'h8001_7F00, 0, 4'b1100, 32'h0, 32'h0000_8001);
        // Half store at lane 0, one wait
        run_access(1'b1, 2'b01, 32'h0000_0300, 32'h1234_BEEF, 32'h0, 1, 4'b0011, 32'hBEEF_BEEF, 32'h0);

        // Timeout: mem_ready never rises, abort after 4 ACCESS cycles
        pad_read = 1'b1; pad_data_size = 2'b11; address = 32'h0000_0040; mem_ready = 1'b0;
        #1 check("to_req_stall", {31'b0, stall}, 32'd1);
        @(posedge clock); #1;
        check("to_valid", {31'b0, mem_valid}, 32'd1);
        @(negedge clock);
        pad_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 check("to_stall", {31'b0, stall}, {31'b0, (i < 3)});
            @(posedge clock); #1;
            check("to_valid_run", {31'b0, mem_valid}, {31'b0, (i < 3)});
            check("to_err", {31'b0, bus_error}, {31'b0, (i == 3)});
            @(negedge clock);
        end
        check("to_rd_clr", read_data, 32'd0);
        check("to_state", 32'(debug_state), 32'(IDLE));
        last_rd = 32'b0;
        @(posedge clock); #1;
        check("to_err_end", {31'b0, bus_error}, 32'd0);
        @(negedge clock);

        // Byte read lane 1 gives a non-zero value before the error clears it
        run_access(1'b0, 2'b00, 32'h0000_0001, 32'h0, 32'h1122_3344, 0, 4'b0010, 32'h0, 32'h0000_0033);
        // Misaligned word, illegal size, both requests, misaligned half
        run_error(1'b1, 1'b0, 2'b11, 32'h0000_0102);
        run_access(1'b0, 2'b01, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 2, 4'b0011, 32'h0, 32'h0000_F00D);
        run_error(1'b1, 1'b0, 2'b10, 32'h0000_0000);
        run_error(1'b1, 1'b1, 2'b11, 32'h0000_0000);
        run_error(1'b0, 1'b1, 2'b01, 32'h0000_0021);

        // Reset mid-ACCESS: mem_valid drops with no clock edge, no error
        pad_read = 1'b1; pad_data_size = 2'b11; address = 32'h0000_0080; mem_ready = 1'b0;
        @(posedge clock); #1;
        check("rst_mid_valid_pre", {31'b0, mem_valid}, 32'd1);
        @(negedge clock);
        pad_read = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_mid_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_mid_state", 32'(debug_state), 32'(IDLE));
        check("rst_mid_err", {31'b0, bus_error}, 32'd0);
        #1 reset = 1'b0;
        last_rd = 32'b0;
        @(posedge clock); #1;
        check("rst_mid_no_err", {31'b0, bus_error}, 32'd0);
        @(negedge clock);
        run_access(1'b0, 2'b11, 32'h0000_0084, 32'h0, 32'h1234_5678, 1, 4'b1111, 32'h0, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
